// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative 32-bit multiply / divide unit with HI/LO result registers.
// One radix-2 step per clock on unsigned magnitudes (shift-add multiply,
// restoring divide), followed by a single sign-correction cycle.
//
// Ports:
//   clk    - sole clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   start  - begin an operation (accepted only while busy is low)
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      - multiplicand / dividend (rs)
//   b      - multiplier / divisor (rt)
//   we_hi  - MTHI write enable (idle only)
//   we_lo  - MTLO write enable (idle only)
//   wd     - MTHI/MTLO write data
//   hi     - HI register (product high word / remainder)
//   lo     - LO register (product low word / quotient)
//   busy   - operation in progress
//   done   - one-cycle pulse after hi/lo receive a new result
// ---------------------------------------------------------------------------

module mul_div_unit_chk (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);

  // done is a single-cycle pulse
  a_done_pulse : assert property (@(posedge clk) disable iff (rst) done |=> !done);

  // a result is only announced once the unit has gone idle
  a_done_idle : assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule

module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  // control strobes decoded from the FSM
  logic        load_s;
  logic        step_s;
  logic        fix_s;

  // latched operation context
  logic        is_div_r;
  logic        sign_a_r;
  logic        sign_b_r;
  logic        div_zero_r;
  logic [31:0] a_orig_r;
  logic [31:0] opnd_r;     // multiplicand magnitude or divisor magnitude
  logic [63:0] work_r;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [4:0]  cnt_r;

  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  // operand preparation at start
  logic        op_signed_s;
  logic        sign_a_s;
  logic        sign_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;

  // iteration datapath
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic        div_ge_s;
  logic [63:0] iter_s;

  // result formation
  logic [63:0] prod_neg_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // FSM next-state and control strobes
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    fix_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        // the counter was cleared at start, so count 31 marks the 32nd step
        if (cnt_r == 5'd31) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX: begin
        fix_s        = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // signs and magnitudes of the incoming operands (abs only for signed ops)
  always_comb begin
    op_signed_s = ~op[0];
    sign_a_s    = op_signed_s & a[31];
    sign_b_s    = op_signed_s & b[31];
    if (sign_a_s) begin
      mag_a_s = 32'd0 - a;
    end else begin
      mag_a_s = a;
    end
    if (sign_b_s) begin
      mag_b_s = 32'd0 - b;
    end else begin
      mag_b_s = b;
    end
  end

  // one radix-2 step of either algorithm
  always_comb begin
    // multiply: add multiplicand when the current multiplier LSB is set, then shift right
    mul_sum_s   = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, opnd_r} : 33'd0);
    // divide: shift next dividend bit into the remainder and trial-subtract
    div_shift_s = {work_r[63:32], work_r[31]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    if (is_div_r) begin
      // remainder stays below the divisor, so the restored value fits 32 bits
      if (div_ge_s) begin
        iter_s = {div_diff_s[31:0], work_r[30:0], 1'b1};
      end else begin
        iter_s = {div_shift_s[31:0], work_r[30:0], 1'b0};
      end
    end else begin
      iter_s = {mul_sum_s, work_r[31:1]};
    end
  end

  // sign correction and special cases applied in the final cycle
  always_comb begin
    prod_neg_s = 64'd0 - work_r;
    quot_s     = work_r[31:0];
    rem_s      = work_r[63:32];
    res_hi_s   = 32'd0;
    res_lo_s   = 32'd0;
    if (!is_div_r) begin
      if (sign_a_r ^ sign_b_r) begin
        res_hi_s = prod_neg_s[63:32];
        res_lo_s = prod_neg_s[31:0];
      end else begin
        res_hi_s = work_r[63:32];
        res_lo_s = work_r[31:0];
      end
    end else if (div_zero_r) begin
      res_hi_s = a_orig_r;
      res_lo_s = 32'hFFFF_FFFF;
    end else begin
      // truncating division: quotient sign from operand signs, remainder follows dividend
      if (sign_a_r ^ sign_b_r) begin
        res_lo_s = 32'd0 - quot_s;
      end else begin
        res_lo_s = quot_s;
      end
      if (sign_a_r) begin
        res_hi_s = 32'd0 - rem_s;
      end else begin
        res_hi_s = rem_s;
      end
    end
  end

  // datapath, HI/LO registers and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_r   <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
      a_orig_r   <= 32'd0;
      opnd_r     <= 32'd0;
      work_r     <= 64'd0;
      cnt_r      <= 5'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= fix_s;

      if (load_s) begin
        is_div_r   <= op[1];
        sign_a_r   <= sign_a_s;
        sign_b_r   <= sign_b_s;
        div_zero_r <= (b == 32'd0);
        a_orig_r   <= a;
        cnt_r      <= 5'd0;
        if (op[1]) begin
          opnd_r <= mag_b_s;
          work_r <= {32'd0, mag_a_s};
        end else begin
          opnd_r <= mag_a_s;
          work_r <= {32'd0, mag_b_s};
        end
      end else if (step_s) begin
        work_r <= iter_s;
        cnt_r  <= cnt_r + 5'd1;
      end else begin
        work_r <= work_r;
        cnt_r  <= cnt_r;
      end

      // result write happens while busy, so MTHI/MTLO can never collide with it
      if (fix_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (state_r == ST_IDLE) begin
        if (we_hi) begin
          hi_r <= wd;
        end else begin
          hi_r <= hi_r;
        end
        if (we_lo) begin
          lo_r <= wd;
        end else begin
          lo_r <= lo_r;
        end
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

  mul_div_unit_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_r),
    .done (done_r)
  );

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for reset, MTHI/MTLO and start-while-busy behaviour.
// ---------------------------------------------------------------------------

module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int done_seen;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [12];

  mul_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wd    (wd),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count done pulses away from the active edge
  always @(negedge clk) begin
    if (done) done_seen = done_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference results straight from the arithmetic definitions
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eh, output logic [31:0] el);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    logic [63:0] t;
    sx = $signed(x);
    sy = $signed(y);
    eh = 32'd0;
    el = 32'd0;
    case (o)
      OP_MULT: begin
        q = sx * sy;
        p = q;
        eh = p[63:32];
        el = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        eh = p[63:32];
        el = p[31:0];
      end
      OP_DIV: begin
        if (y == 32'd0) begin
          eh = x;
          el = 32'hFFFF_FFFF;
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = q;
          t = r;
          el = p[31:0];
          eh = t[31:0];
        end
      end
      default: begin
        if (y == 32'd0) begin
          eh = x;
          el = 32'hFFFF_FFFF;
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  // wait (bounded) for busy to drop; returns number of busy samples seen
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      n = n + 1;
      tick();
    end
  endtask

  // full operation with timing checks; operands are scrambled after the start edge
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    int d0;
    int dbusy;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();                       // edge N
    start = 1'b0;
    op    = 2'($urandom_range(3, 0));
    a     = $urandom;
    b     = $urandom;
    d0    = done_seen;
    n     = 0;
    dbusy = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      n = n + 1;
      if (done) dbusy = dbusy + 1;
      tick();
    end
    check({name, " busy cycles"}, n, 32'd33);
    check({name, " done while busy"}, dbusy, 32'd0);
    check({name, " done at idle"}, {31'd0, done}, 32'd1);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    tick();
    check({name, " done drop"}, {31'd0, done}, 32'd0);
    check({name, " done count"}, done_seen - d0, 32'd1);
  endtask

  initial begin
    int          n;
    int          d0;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eh;
    logic [31:0] el;

    checks    = 0;
    errors    = 0;
    done_seen = 0;
    rst   = 1'b1;
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd3;
    b     = 32'd4;
    we_hi = 1'b1;
    we_lo = 1'b1;
    wd    = 32'hCAFE_F00D;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
    vecs[10] = '{OP_DIVU,  32'd9,         32'd2,         32'h0000_0001, 32'h0000_0004};
    vecs[11] = '{OP_MULTU, 32'd0,         32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

    // reset overrides start and writes
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    tick();
    check("idle after reset", {31'd0, busy}, 32'd0);

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
    end

    // MTLO / MTHI while idle, then writes ignored while busy
    we_lo = 1'b1;
    wd    = 32'h1234_5678;
    tick();
    we_lo = 1'b0;
    check("mtlo lo", lo, 32'h1234_5678);
    we_hi = 1'b1;
    we_lo = 1'b1;
    wd    = 32'hA5A5_5A5A;
    tick();
    we_hi = 1'b0;
    we_lo = 1'b0;
    check("mthi+mtlo hi", hi, 32'hA5A5_5A5A);
    check("mthi+mtlo lo", lo, 32'hA5A5_5A5A);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd9;
    b     = 32'd2;
    tick();
    start = 1'b0;
    we_lo = 1'b1;
    we_hi = 1'b1;
    wd    = 32'h1234_5678;
    tick();
    we_lo = 1'b0;
    we_hi = 1'b0;
    check("busy write lo", lo, 32'hA5A5_5A5A);
    check("busy write hi", hi, 32'hA5A5_5A5A);
    wait_idle(n);
    check("busy write result lo", lo, 32'd4);
    check("busy write result hi", hi, 32'd1);

    // start ignored while busy: second request at edge N+5
    tick();
    d0    = done_seen;
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd9;
    b     = 32'd2;
    tick();                       // edge N
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd2;
    b     = 32'd3;
    tick();                       // edge N+5
    start = 1'b0;
    wait_idle(n);
    check("ignored start busy tail", n, 32'd28);
    check("ignored start lo", lo, 32'd4);
    check("ignored start hi", hi, 32'd1);
    for (int i = 0; i < 40; i++) tick();
    check("ignored start done count", done_seen - d0, 32'd1);
    check("ignored start idle", {31'd0, busy}, 32'd0);

    // write and start in the same idle cycle
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd5;
    b     = 32'd6;
    we_hi = 1'b1;
    wd    = 32'h1111_2222;
    tick();
    start = 1'b0;
    we_hi = 1'b0;
    check("start+mthi hi", hi, 32'h1111_2222);
    check("start+mthi busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("start+mthi result hi", hi, 32'd0);
    check("start+mthi result lo", lo, 32'd30);

    // reset mid-run aborts without a done pulse
    tick();
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd5;
    b     = 32'd5;
    tick();                       // edge N
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    d0  = done_seen;
    rst = 1'b1;
    tick();                       // edge N+10
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    check("abort no done", done_seen - d0, 32'd0);
    check("abort lo held", lo, 32'd0);
    do_op("after abort", OP_MULTU, 32'd5, 32'd5, 32'd0, 32'd25);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(3, 0));
      ra = $urandom;
      rb = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3, 0) == 0) rb = 32'($urandom_range(15, 0)) - 32'd8;
      ref_model(ro, ra, rb, eh, el);
      do_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, eh, el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand (register-file rd1); multiplicand or dividend.
REQ-007 b  input  32  rt operand (register-file rd2); multiplier or divisor.
REQ-008 we_hi  input  1  MTHI write enable.
REQ-009 we_lo  input  1  MTLO write enable.
REQ-010 wd  input  32  MTHI/MTLO write data.
REQ-011 hi  output  32  HI register contents (MFHI source).
REQ-012 lo  output  32  LO register contents (MFLO source).
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse when hi/lo receive a new result.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIX; busy=1 in RUN and FIX, busy=0 in IDLE.
REQ-016 IDLE with start=1 at edge N: SHALL latch op, |a|, |b| (abs only for signed ops), operand signs; enter RUN; clear 5-bit iteration counter.
REQ-017 RUN SHALL perform one radix-2 iteration per cycle (shift-add multiply or restoring divide on unsigned magnitudes) for exactly 32 cycles (edges N+1..N+32), then enter FIX.
REQ-018 FIX (edge N+33) SHALL apply sign correction, write hi/lo, assert done for the following cycle only, return to IDLE.
REQ-019 busy SHALL be high in the cycles after edges N..N+32 (33 cycles) and low from edge N+33.
REQ-020 MULT/MULTU: {hi,lo} SHALL equal the 64-bit product; MULT result negated (two's complement, 64-bit) when operand signs differ.
REQ-021 DIV/DIVU: lo SHALL be quotient, hi remainder; signed quotient negated when signs differ; signed remainder takes sign of dividend (truncating division).
REQ-022 Divide by zero (DIV or DIVU): lo SHALL be 32'hFFFFFFFF, hi SHALL be original a; still 33 busy cycles.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF: lo SHALL be 32'h80000000, hi 32'h0 (no trap).
REQ-024 start while busy=1 SHALL be ignored; no queuing.
REQ-025 we_hi/we_lo while busy=0 SHALL load wd into hi/lo at that edge; both may be set together; ignored while busy=1.
REQ-026 start and we_hi/we_lo in same IDLE cycle: write SHALL apply at that edge; operation starts; its result later overwrites hi/lo.
REQ-027 a, b, op SHALL be don't-care after the start edge; internal copies used exclusively.
REQ-028 hi/lo SHALL hold their value in all cycles other than REQ-018 and REQ-025 updates.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, counter=0, overriding start and writes.
REQ-030 rst during RUN or FIX SHALL abort the operation with no done pulse and no hi/lo update other than clearing.

Verification
REQ-031 MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done one cycle after edge N+33, busy 33 cycles.
REQ-032 MULT a=-3 b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-033 DIVU a=100 b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064; DIV a=32'h80000000 b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-034 Second start (MULTU 2*3) at edge N+5 during DIVU 9/2 -> ignored; result lo=4, hi=1; only one done pulse.
REQ-035 rst asserted at edge N+10 of MULTU 5*5 -> busy=0, hi=lo=0 next cycle, no done pulse ever; fresh start afterwards completes normally.
REQ-036 Idle we_lo=1 wd=32'h12345678 -> lo=32'h12345678 next cycle; same write during busy -> lo unchanged until result.
